// File: rtl/alu_wb_buffer.sv
// Purpose: buffers ALU results in an in-order FIFO and drains them to the PRF write port, ROB and BPU.
// Latency: an entry pushed at edge t is at the head and can complete at t+1. Optional macro: ALU_WB_PERF_CNT_EN.
// Backpressure: alu_stall_o is raised from registers when the FIFO is full; the head waits for a PRF grant.
module alu_wb_buffer #(
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int VIRTUAL_ADDR_LEN     = 39,
  parameter int EXCEPTION_CODE_WIDTH = 4,
  parameter int DEPTH                = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            alu_done_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i,
  input  logic [XLEN-1:0]                 alu_result_i,
  input  logic                            alu_cmp_result_i,
  input  logic                            alu_jump_i,
  input  logic                            alu_branch_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     alu_pc_i,
  input  logic [VIRTUAL_ADDR_LEN-1:0]     alu_next_pc_i,
  input  logic                            alu_exception_valid_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i,
  output logic                            alu_stall_o,
  output logic                            prf_wr_req_o,
  input  logic                            prf_wr_grant_i,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   prf_wr_addr_o,
  output logic [XLEN-1:0]                 prf_wr_data_o,
  output logic                            rob_cmp_valid_o,
  output logic [ROB_INDEX_WIDTH-1:0]      rob_cmp_index_o,
  output logic                            rob_cmp_exception_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] rob_cmp_ecause_o,
  output logic                            bpu_update_valid_o,
  output logic                            bpu_jump_o,
  output logic                            bpu_taken_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bpu_pc_o,
  output logic [VIRTUAL_ADDR_LEN-1:0]     bpu_target_o
`ifdef ALU_WB_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_stall_cycles_o,
  output logic [31:0]                     perf_completed_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd;
    logic [ROB_INDEX_WIDTH-1:0]      rob;
    logic [XLEN-1:0]                 result;
    logic                            cmp;
    logic                            jump;
    logic                            branch;
    logic [VIRTUAL_ADDR_LEN-1:0]     pc;
    logic [VIRTUAL_ADDR_LEN-1:0]     next_pc;
    logic                            exc;
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]     count_q, count_d;
  logic            hv, wn, push, pop;

  // Stall comes straight from the occupancy register so the ALU sees no input-to-stall path.
  assign alu_stall_o = (count_q == FULL_CNT);

  // Head decode, handshake qualification and all drain-side outputs.
  always_comb begin
    prf_wr_req_o        = 1'b0;
    prf_wr_addr_o       = '0;
    prf_wr_data_o       = '0;
    rob_cmp_valid_o     = 1'b0;
    rob_cmp_index_o     = '0;
    rob_cmp_exception_o = 1'b0;
    rob_cmp_ecause_o    = '0;
    bpu_update_valid_o  = 1'b0;
    bpu_jump_o          = 1'b0;
    bpu_taken_o         = 1'b0;
    bpu_pc_o            = '0;
    bpu_target_o        = '0;

    head = mem_q[rptr_q];
    hv   = (count_q != '0);
    wn   = hv & ~head.exc & (head.rd != '0);
    push = alu_done_i & ~alu_stall_o & ~flush;
    // A grant offered while the head needs no write is simply ignored.
    pop  = hv & (~wn | prf_wr_grant_i) & ~flush;

    // Request is withheld during flush so an arbiter cannot commit a write that is being discarded.
    prf_wr_req_o = wn & ~flush;
    if (hv) begin
      prf_wr_addr_o = head.rd;
      prf_wr_data_o = head.result;
    end

    if (pop) begin
      rob_cmp_valid_o     = 1'b1;
      rob_cmp_index_o     = head.rob;
      rob_cmp_exception_o = head.exc;
      rob_cmp_ecause_o    = head.ecause;
      // Branches still train the predictor even when they raised an exception.
      if (head.jump | head.branch) begin
        bpu_update_valid_o = 1'b1;
        bpu_jump_o         = head.jump;
        bpu_taken_o        = head.jump | (head.branch & head.cmp);
        bpu_pc_o           = head.pc;
        bpu_target_o       = head.next_pc;
      end
    end

    rptr_d  = pop  ? rptr_q + PTR_ONE : rptr_q;
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // Pointer and occupancy state; flush empties the queue, dropping any ungranted write.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= '{rd: alu_rd_addr_i, rob: alu_rob_index_i, result: alu_result_i,
                         cmp: alu_cmp_result_i, jump: alu_jump_i, branch: alu_branch_i,
                         pc: alu_pc_i, next_pc: alu_next_pc_i,
                         exc: alu_exception_valid_i, ecause: alu_ecause_i};
    end
  end

`ifdef ALU_WB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_cmp_q;

  // Saturating event counters; only reset clears them, flush leaves them running.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_stall_q <= '0;
      perf_cmp_q   <= '0;
    end else begin
      if (alu_stall_o && alu_done_i && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      if (pop && perf_cmp_q != 32'hFFFF_FFFF) perf_cmp_q <= perf_cmp_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_completed_o    = perf_cmp_q;
`endif

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
Result-side receiver for the single-cycle integer ALU execution unit. It accepts the ALU's registered outputs (done, rd, rob index, result, cmp result, jump/branch, pc, exception) under a valid/ready handshake and buffers them in a small in-order FIFO. It drains each entry to three destinations: the shared physical-register-file write port (arbitrated), the ROB completion interface, and the branch-predictor update interface. It drives the ALU's stall input.

Parameters:
XLEN, 64, data width
PHY_REG_ADDR_WIDTH, 6, physical register index width
ROB_INDEX_WIDTH, 4, ROB index width
VIRTUAL_ADDR_LEN, 39, pc width
EXCEPTION_CODE_WIDTH, 4, ecause width
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
flush  in  1  pipeline flush, synchronous
alu_done_i  in  1  ALU result valid
alu_rd_addr_i  in  PHY_REG_ADDR_WIDTH  destination preg; 0 = no write
alu_rob_index_i  in  ROB_INDEX_WIDTH  ROB slot
alu_result_i  in  XLEN  ALU result
alu_cmp_result_i  in  1  branch compare outcome
alu_jump_i  in  1  op is jump
alu_branch_i  in  1  op is conditional branch
alu_pc_i  in  VIRTUAL_ADDR_LEN  instruction pc
alu_next_pc_i  in  VIRTUAL_ADDR_LEN  resolved target
alu_exception_valid_i  in  1  op raised exception
alu_ecause_i  in  EXCEPTION_CODE_WIDTH  exception code
alu_stall_o  out  1  backpressure to ALU stall input
prf_wr_req_o  out  1  request PRF write port
prf_wr_grant_i  in  1  PRF write port granted this cycle
prf_wr_addr_o  out  PHY_REG_ADDR_WIDTH  write address
prf_wr_data_o  out  XLEN  write data
rob_cmp_valid_o  out  1  completion pulse
rob_cmp_index_o  out  ROB_INDEX_WIDTH  completing ROB slot
rob_cmp_exception_o  out  1  completion carries exception
rob_cmp_ecause_o  out  EXCEPTION_CODE_WIDTH  exception code
bpu_update_valid_o  out  1  predictor update pulse
bpu_jump_o  out  1  update is jump
bpu_taken_o  out  1  resolved taken
bpu_pc_o  out  VIRTUAL_ADDR_LEN  branch pc
bpu_target_o  out  VIRTUAL_ADDR_LEN  resolved target

Behaviour:
- Reset: rstn synchronous, active-low. rptr, wptr, count <= 0. Every output is 0 after the reset edge, including alu_stall_o. Data payload is not reset.
- Storage: DEPTH-entry circular FIFO. rptr/wptr are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- alu_stall_o = (count == DEPTH). Derived from registers only; no combinational path from any input.
- Push: alu_done_i & ~alu_stall_o & ~flush. Writes all alu_* fields at wptr; wptr++.
- While stall is high, the ALU holds its outputs. The held entry is accepted in the first cycle stall is low; there is no duplicate and no loss.
- Head valid: hv = (count != 0). Head write needed: wn = hv & ~exc & (rd != 0).
- prf_wr_req_o = wn. prf_wr_addr_o and prf_wr_data_o = head fields, zero when ~hv.
- Pop: pop = hv & (~wn | prf_wr_grant_i) & ~flush. rptr++ on pop.
- Grant while ~wn is ignored. Head stays stable until popped; no reordering.
- In the pop cycle, rob_cmp_valid_o = 1. rob_cmp_index, rob_cmp_exception and rob_cmp_ecause = head fields. Otherwise all four are 0.
- In the pop cycle, bpu_update_valid_o = head.jump | head.branch. bpu_jump_o = jump. bpu_taken_o = jump | (branch & cmp_result). bpu_pc_o = pc. bpu_target_o = next_pc. All are 0 when no update.
- Exception entry: no PRF write; completion carries exception. A branch with an exception still updates the BPU.
- Simultaneous push and pop: count unchanged. Pop while full releases stall on the next cycle, not the same cycle.
- Latency: push at edge t means the entry is head at t+1. Minimum alu_done_i-to-rob_cmp_valid_o is 1 cycle.
- Flush: synchronous. At the edge, rptr = wptr = count = 0. The push and pop in the flush cycle are suppressed, so no completion, PRF write or BPU update is emitted during the flush cycle. Outputs are 0 in the following cycle.
- Reset or flush mid-drain: a pending, ungranted write is dropped; there is no partial state.

Optional Feature:
Macro ALU_WB_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles_o[31:0] and perf_completed_o[31:0].
  - perf_stall_cycles_o increments each cycle alu_stall_o & alu_done_i.
  - perf_completed_o increments on each pop.
  - Both saturate at 0xFFFFFFFF, are cleared by reset only, and are not affected by flush.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Single op: done with rd=5, result=0x1234, rob=3, grant=1 -> next cycle prf_wr_req=1, addr=5, data=0x1234; rob_cmp_valid=1, index=3; next cycle all 0.
- Fill/backpressure: grant=0, rd=1..5 back-to-back -> stall=1 after the 4th push edge and the rd=5 entry is held. Raise grant -> writes 1,2,3,4,5 in order, one per cycle, and stall drops one cycle after the first pop. No entry is duplicated.
- No-write entry: rd=0, grant=0 -> completion pulse the next cycle with prf_wr_req=0.
- Exception: exception_valid=1, ecause=2, rd=7 -> no PRF request; rob_cmp_exception=1, ecause=2.
- Branch: branch=1, cmp=0, pc=0x1000, next_pc=0x1004 -> bpu_update_valid=1, taken=0, pc=0x1000, target=0x1004. Same with jump=1 -> taken=1, jump=1.
- Flush: 3 entries queued with grant=0, flush pulsed with a simultaneous done -> next cycle count=0, stall=0, no completion or PRF request. A new op afterwards completes normally.
